// File: rtl/serial_word_rx.sv
// Serial bit collector: assembles qualified bits into WIDTH-bit words behind a
// one-word valid/ready holding register, with a sticky flag for dropped words.
module serial_word_rx #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     bit_in,
   input  logic                     bit_valid,
   input  logic                     sof,
   output logic [WIDTH-1:0]         word_out,
   output logic                     word_valid,
   input  logic                     word_ready,
   output logic                     overflow,
   input  logic                     clr_ovf,
   output logic [$clog2(WIDTH)-1:0] bit_cnt
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   shift_reg, shift_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   logic [WIDTH-1:0]   word_reg, word_next;
   logic               valid_reg, valid_next;
   logic               ovf_reg, ovf_next;
   logic [WIDTH-1:0]   shift_fresh, shift_more;
   logic               complete;
   logic               hold_free;

   // Shift direction puts the first transmitted bit at the MSB or the LSB of the finished word.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign shift_fresh = {{(WIDTH-1){1'b0}}, bit_in};
         assign shift_more  = {shift_reg[WIDTH-2:0], bit_in};
      end else begin : g_lsb_first
         assign shift_fresh = {bit_in, {(WIDTH-1){1'b0}}};
         assign shift_more  = {bit_in, shift_reg[WIDTH-1:1]};
      end
   endgenerate

   assign hold_free = ~valid_reg | word_ready;

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      cnt_next   = cnt_reg;
      complete   = 1'b0;
      word_next  = word_reg;
      valid_next = valid_reg;
      ovf_next   = ovf_reg;

      if (bit_valid) begin
         if (sof) begin
            // sof always restarts framing; any partial word is silently abandoned
            shift_next = shift_fresh;
            cnt_next   = CW'(1);
            state_next = SHIFT;
         end else if (state_reg == SHIFT) begin
            shift_next = shift_more;
            if (cnt_reg == LAST_CNT) begin
               cnt_next = '0;
               complete = 1'b1;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
      end

      if (complete && hold_free) begin
         word_next  = shift_more;
         valid_next = 1'b1;
      end else if (valid_reg && word_ready) begin
         valid_next = 1'b0;
      end

      if (complete && !hold_free) begin
         ovf_next = 1'b1;
      end else if (clr_ovf) begin
         ovf_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         cnt_reg   <= '0;
         word_reg  <= '0;
         valid_reg <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         cnt_reg   <= cnt_next;
         word_reg  <= word_next;
         valid_reg <= valid_next;
         ovf_reg   <= ovf_next;
      end
   end

   assign word_out   = word_reg;
   assign word_valid = valid_reg;
   assign overflow   = ovf_reg;
   assign bit_cnt    = cnt_reg;

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: one MSB-first and one LSB-first instance share
// the same stimulus; a vector table covers the streaming case, sequences the corners.
module tb_serial_word_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, bit_in, bit_valid, sof, word_ready, clr_ovf;
   logic [7:0] wm, wl;
   logic       vm, vl, om, ol;
   logic [2:0] cm, cl;

   serial_word_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
      .word_out(wm), .word_valid(vm), .word_ready(word_ready),
      .overflow(om), .clr_ovf(clr_ovf), .bit_cnt(cm));

   serial_word_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
      .word_out(wl), .word_valid(vl), .word_ready(word_ready),
      .overflow(ol), .clr_ovf(clr_ovf), .bit_cnt(cl));

   typedef struct {
      logic       sof, bv, bit_in, rdy, clr;
      logic       exp_valid;
      logic [7:0] exp_wm, exp_wl;
      logic       exp_ovf;
      logic [2:0] exp_cnt;
   } vec_t;

   vec_t vecs [19];
   int   total  = 0;
   int   passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Compares MSB-first instance state plus the LSB-first word and valid.
   task automatic check_state(input string tag, input logic ev, input logic [7:0] ewm,
                              input logic [7:0] ewl, input logic eo, input logic [2:0] ec);
      check({tag, ".valid"},   32'(vm), 32'(ev));
      check({tag, ".word_m"},  32'(wm), 32'(ewm));
      check({tag, ".word_l"},  32'(wl), 32'(ewl));
      check({tag, ".ovf"},     32'(om), 32'(eo));
      check({tag, ".cnt"},     32'(cm), 32'(ec));
      check({tag, ".valid_l"}, 32'(vl), 32'(ev));
      $display("%s: valid=%0b word_m=%02h word_l=%02h ovf=%0b cnt=%0d", tag, vm, wm, wl, om, cm);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Sends v[n-1:0] in order, first bit optionally flagged sof, with idle gaps between bits.
   task automatic send_bits(input logic [7:0] v, input int n, input logic first_sof, input int gap);
      for (int i = n - 1; i >= 0; i--) begin
         bit_in    = v[i];
         bit_valid = 1'b1;
         sof       = (i == n - 1) ? first_sof : 1'b0;
         tick;
         bit_valid = 1'b0;
         sof       = 1'b0;
         if (i > 0) repeat (gap) tick;
      end
   endtask

   initial begin
      // sof bv bit rdy clr | valid word_m word_l ovf cnt
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd2};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd3};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd4};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd5};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd6};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd7};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 3'd0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd0};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd1};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd2};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd2};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd3};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd4};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd5};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd6};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd7};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC0, 8'h03, 1'b0, 3'd0};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC0, 8'h03, 1'b0, 3'd0};

      // Reset held with random activity on every input
      reset = 1'b0;
      word_ready = 1'b0;
      bit_valid = 1'b0; sof = 1'b0; bit_in = 1'b0; clr_ovf = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bit_in     = 1'($urandom);
         bit_valid  = 1'($urandom);
         sof        = 1'($urandom);
         word_ready = 1'($urandom);
         clr_ovf    = 1'($urandom);
         tick;
      end
      check_state("reset", 1'b0, 8'h00, 8'h00, 1'b0, 3'd0);
      bit_valid = 1'b0; sof = 1'b0; bit_in = 1'b0; clr_ovf = 1'b0; word_ready = 1'b1;
      #2 reset = 1'b1;
      tick;

      // Streaming words, continuous framing, ignored sof without bit_valid
      for (int r = 0; r < 19; r++) begin
         sof = vecs[r].sof; bit_valid = vecs[r].bv; bit_in = vecs[r].bit_in;
         word_ready = vecs[r].rdy; clr_ovf = vecs[r].clr;
         tick;
         check_state($sformatf("row%0d", r), vecs[r].exp_valid, vecs[r].exp_wm,
                     vecs[r].exp_wl, vecs[r].exp_ovf, vecs[r].exp_cnt);
      end
      bit_valid = 1'b0; sof = 1'b0; clr_ovf = 1'b0;

      // Bits before the first sof are ignored; gapped bits assemble identically
      reset = 1'b0; #2 reset = 1'b1;
      send_bits(8'hE0, 3, 1'b0, 0);
      check_state("pre_sof", 1'b0, 8'h00, 8'h00, 1'b0, 3'd0);
      send_bits(8'hA5, 8, 1'b1, 3);
      check_state("gapped", 1'b1, 8'hA5, 8'hA5, 1'b0, 3'd0);
      tick;
      check_state("gapped_consumed", 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd0);

      // Restart mid-word and on the completing slot
      send_bits(8'h1F, 5, 1'b1, 0);
      check_state("partial5", 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd5);
      send_bits(8'h3C, 8, 1'b1, 0);
      check_state("restart", 1'b1, 8'h3C, 8'h3C, 1'b0, 3'd0);
      tick;
      send_bits(8'h7F, 7, 1'b1, 0);
      check_state("partial7", 1'b0, 8'h3C, 8'h3C, 1'b0, 3'd7);
      send_bits(8'h00, 1, 1'b1, 0);
      check_state("sof_on_last", 1'b0, 8'h3C, 8'h3C, 1'b0, 3'd1);
      send_bits(8'h3C, 7, 1'b0, 0);
      check_state("restart_last", 1'b1, 8'h3C, 8'h3C, 1'b0, 3'd0);
      tick;

      // Backpressure, overflow, clear, set-over-clear priority
      word_ready = 1'b0;
      send_bits(8'h11, 8, 1'b1, 0);
      check_state("bp_first", 1'b1, 8'h11, 8'h88, 1'b0, 3'd0);
      send_bits(8'h22, 8, 1'b0, 0);
      check_state("bp_drop", 1'b1, 8'h11, 8'h88, 1'b1, 3'd0);
      word_ready = 1'b1;
      tick;
      check_state("bp_consume", 1'b0, 8'h11, 8'h88, 1'b1, 3'd0);
      clr_ovf = 1'b1;
      tick;
      clr_ovf = 1'b0;
      check_state("clr_ovf", 1'b0, 8'h11, 8'h88, 1'b0, 3'd0);
      word_ready = 1'b0;
      send_bits(8'h33, 8, 1'b1, 0);
      clr_ovf = 1'b1;
      send_bits(8'h44, 8, 1'b0, 0);
      check_state("set_over_clr", 1'b1, 8'h33, 8'hCC, 1'b1, 3'd0);
      tick;
      clr_ovf = 1'b0;
      check_state("clr_after", 1'b1, 8'h33, 8'hCC, 1'b0, 3'd0);

      // Asynchronous reset mid-word and while holding a word with overflow set
      word_ready = 1'b1;
      tick;
      send_bits(8'h0A, 4, 1'b1, 0);
      check_state("mid4", 1'b0, 8'h33, 8'hCC, 1'b0, 3'd4);
      #2 reset = 1'b0;
      #1 check_state("async_mid", 1'b0, 8'h00, 8'h00, 1'b0, 3'd0);
      #1 reset = 1'b1;
      word_ready = 1'b0;
      send_bits(8'h55, 8, 1'b1, 0);
      send_bits(8'h66, 8, 1'b0, 0);
      check_state("pre_async", 1'b1, 8'h55, 8'hAA, 1'b1, 3'd0);
      #2 reset = 1'b0;
      #1 check_state("async_full", 1'b0, 8'h00, 8'h00, 1'b0, 3'd0);
      #1 reset = 1'b1;
      word_ready = 1'b1;
      send_bits(8'hF0, 8, 1'b1, 0);
      check_state("after_reset", 1'b1, 8'hF0, 8'h0F, 1'b0, 3'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
